// File: rtl/chattering.sv
// rtl/chattering.sv - push-button debouncer (chattering filter)
//
// Purpose:
//   Brings a raw, asynchronous, bouncing push-button level into the clk
//   domain. The level is sampled once per tick. The debounced output moves
//   only after STABLE_SAMPLES consecutive samples agree.
//
// Parameters:
//   CLK_DIV         clk cycles per sample tick (>= 2)
//   STABLE_SAMPLES  consecutive equal samples needed to change btn_out (>= 2)
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   asynchronous active-low reset
//   btn      in   raw button level, asynchronous; released = 1, pressed = 0
//   btn_out  out  debounced button level, same polarity as btn, registered
`timescale 1ns/1ps

module chattering #(
   parameter int CLK_DIV        = 50000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic btn_out
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_DIV - 1);

   logic                      sync1;
   logic                      sync2;
   logic [CW-1:0]             count;
   logic                      tick;
   logic [STABLE_SAMPLES-1:0] samples;
   logic [STABLE_SAMPLES-1:0] samples_next;

   // Tick is a one-cycle strobe on the last count value, so tick edges are
   // exactly CLK_DIV cycles apart across the wrap.
   assign tick = (count == COUNT_LAST);

   // Vector the sample register will hold after this tick edge; btn_out is
   // decided from it so the decision and the shift happen on the same edge.
   assign samples_next = {samples[STABLE_SAMPLES-2:0], sync2};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         count   <= '0;
         samples <= '1;
         btn_out <= 1'b1;
      end else begin
         // Two-flop synchroniser for the asynchronous button level.
         sync1 <= btn;
         sync2 <= sync1;

         if (tick) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end

         if (tick) begin
            samples <= samples_next;
            // Mixed samples leave btn_out untouched, so alternating or
            // glitchy samples hold the last stable level.
            if (&samples_next) begin
               btn_out <= 1'b1;
            end else if (~|samples_next) begin
               btn_out <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_chattering.sv
// tb/tb_chattering.sv - self-checking bench for the chattering debouncer
`timescale 1ns/1ps

module tb_chattering;

   localparam int CD = 10;
   localparam int SS = 3;
   localparam int LAT_MIN = (SS - 1) * CD + 3;
   localparam int LAT_MAX = SS * CD + 2;

   logic clk;
   logic rst;
   logic btn;
   logic btn_out;
   bit   clk_en;

   int checks = 0;
   int errors = 0;

   chattering #(
      .CLK_DIV        (CD),
      .STABLE_SAMPLES (SS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn),
      .btn_out (btn_out)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #10;
         if (clk_en) clk = ~clk;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // ---------------- reference model ----------------
   // Output follows the rule: on every CD-th edge after reset release the
   // button level seen two edges earlier is recorded; when the last SS
   // recorded levels all agree, the output takes that level.
   int unsigned cyc = 0;
   int          since_rel = 0;
   bit          hist[$];
   bit          rec[$];
   bit          exp_out = 1'b1;
   int unsigned exp_cyc[$];
   bit          exp_val[$];
   bit          exp_rst[$];

   task automatic push_expect(input bit v, input bit from_rst);
      exp_out = v;
      exp_cyc.push_back(cyc);
      exp_val.push_back(v);
      exp_rst.push_back(from_rst);
   endtask

   task automatic model_reset();
      since_rel = 0;
      hist.delete();
      hist.push_back(1'b1);
      hist.push_back(1'b1);
      rec.delete();
      for (int i = 0; i < SS; i++) rec.push_back(1'b1);
      if (exp_out != 1'b1) push_expect(1'b1, 1'b1);
   endtask

   task automatic model_step();
      bit delayed;
      int ones;
      delayed = hist.pop_front();
      hist.push_back(btn);
      since_rel++;
      if (since_rel % CD == 0) begin
         void'(rec.pop_front());
         rec.push_back(delayed);
         ones = 0;
         foreach (rec[i]) ones += int'(rec[i]);
         if (ones == SS && !exp_out) push_expect(1'b1, 1'b0);
         else if (ones == 0 && exp_out) push_expect(1'b0, 1'b0);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst) model_step();
      else     model_reset();
   end

   always @(negedge rst) model_reset();

   // ---------------- monitor ----------------
   initial begin
      bit seen;
      bit v;
      bit r;
      int unsigned c;
      seen = 1'b1;
      forever begin
         @(negedge clk);
         if (btn_out !== seen) begin
            if (exp_val.size() == 0) begin
               check("unexpected_btn_out_change", int'(btn_out), int'(seen));
            end else begin
               c = exp_cyc.pop_front();
               v = exp_val.pop_front();
               r = exp_rst.pop_front();
               check("btn_out_value", int'(btn_out), int'(v));
               if (!r) check("btn_out_change_cycle", int'(cyc), int'(c));
            end
            seen = btn_out;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset(input int hold);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (hold) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic wait_level(input bit v, input string name);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done && n < LAT_MAX + 10) begin
         @(posedge clk);
         n++;
         #1;
         if (btn_out == v) done = 1'b1;
      end
      check($sformatf("%s_latency_in_range_n%0d", name, n),
            int'(done && n >= LAT_MIN && n <= LAT_MAX), 1);
   endtask

   initial begin
      int r;
      clk_en = 1'b0;
      rst = 1'b1;
      btn = 1'b1;

      // Test 1: asynchronous reset with no clock, then release.
      #5 rst = 1'b0;
      #100 check("reset_async_no_clock", int'(btn_out), 1);
      clk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("reset_release_hold", int'(btn_out), 1);

      // Test 2: short bounce burst, then idle high.
      @(posedge clk);
      #1 btn = 1'b0;
      #10 btn = 1'b1;
      #20 btn = 1'b0;
      #30 btn = 1'b1;
      #40 btn = 1'b0;
      #20 btn = 1'b1;
      #50 btn = 1'b0;
      #10 btn = 1'b1;
      repeat (6000) @(posedge clk);
      #1 check("bounce_burst_ignored", int'(btn_out), 1);

      // Test 3: clean press and release.
      @(posedge clk);
      #1 btn = 1'b0;
      wait_level(1'b0, "press");
      repeat (100) @(posedge clk);
      #1 btn = 1'b1;
      wait_level(1'b1, "release");
      repeat (100) @(posedge clk);

      // Test 4: exact latency from just after a tick edge.
      do_reset(2);
      repeat (CD) @(posedge clk);
      #1 btn = 1'b0;
      repeat (SS * CD - 1) @(posedge clk);
      #1 check("exact_latency_not_early", int'(btn_out), 1);
      @(posedge clk);
      #1 check("exact_latency_on_time", int'(btn_out), 0);

      // Asynchronous reset while btn_out is low.
      @(posedge clk);
      #1 rst = 1'b0;
      #2 check("async_reset_from_low", int'(btn_out), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (50) @(posedge clk);

      // Test 5: samples alternate every tick.
      #1 btn = 1'b1;
      do_reset(2);
      for (int i = 0; i < 20; i++) begin
         repeat (CD) @(posedge clk);
         #1 btn = ~btn;
      end
      #1 check("alternating_hold", int'(btn_out), 1);

      // Test 6: reset after two low samples restarts collection.
      btn = 1'b1;
      do_reset(2);
      repeat (CD) @(posedge clk);
      #1 btn = 1'b0;
      repeat (2 * CD) @(posedge clk);
      #1 rst = 1'b0;
      #2 check("mid_transition_reset", int'(btn_out), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (SS * CD - 1) @(posedge clk);
      #1 check("post_reset_not_early", int'(btn_out), 1);
      @(posedge clk);
      #1 check("post_reset_falls", int'(btn_out), 0);

      // Randomized levels, bursts and occasional resets.
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 29));
         if (r == 0) begin
            do_reset(int'($urandom_range(1, 3)));
         end else if (r < 8) begin
            repeat ($urandom_range(1, 5)) begin
               @(posedge clk);
               #1 btn = ~btn;
            end
         end else begin
            @(posedge clk);
            #1 btn = 1'($urandom_range(0, 1));
         end
         repeat ($urandom_range(1, 40)) @(posedge clk);
      end

      repeat (SS * CD + 20) @(posedge clk);
      #1 check("pending_expectations", exp_val.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
